dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
- Channel-priority resolver and service lock for the 8237A-style DMA core.
- Takes the four DREQ pins, software requests and mask bits, and selects one winning channel.
- Presents the winner to the timing-control FSM as a one-hot VALID_DREG and drives that channel's DACK during service.
- Supports fixed priority (ch0 highest) and rotating priority (the last-serviced channel becomes lowest).

Parameters:
- SYNC_STAGES, 1, number of DREQ input flops (0..2). 0 means DREQ is used directly.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- DREQ  in  4  external DMA requests; polarity set by cmd_dreq_low.
- mask_reg  in  4  per-channel mask; 1 = channel ignored for DREQ.
- sw_req  in  4  software request bits; never masked.
- cmd_disable  in  1  command bit 2; 1 = no new arbitration.
- cmd_rotate  in  1  command bit 4; 1 = rotating priority.
- cmd_dreq_low  in  1  command bit 6; 1 = DREQ active low.
- cmd_dack_high  in  1  command bit 7; 1 = DACK active high.
- svc_start  in  1  one-cycle pulse from timing control at S1 entry (HLDA seen).
- svc_done  in  1  one-cycle pulse from timing control on return to SI (EOP or end of transfer).
- VALID_DREG  out  4  one-hot pending/serviced channel; 0 when none.
- grant_ch  out  2  encoded winning channel; valid when VALID_DREG != 0.
- DACK  out  4  acknowledge pins, polarity per cmd_dack_high.
- prio_ptr  out  2  current highest-priority channel.
- sw_req_clr  out  4  one-cycle pulse clearing the serviced sw_req bit.

Behaviour:
- Effective request:
  - req_eff[i] = (sync(DREQ[i]) XOR cmd_dreq_low) & ~mask_reg[i], OR sw_req[i].
  - DREQ latency with SYNC_STAGES=1 is 1 cycle.
- Winner: the first set req_eff bit scanning upward from prio_ptr, modulo 4. prio_ptr is 0 whenever cmd_rotate=0.
- States:
  - IDLE: VALID_DREG=0, dack_act=0.
    - If cmd_disable=0 and req_eff!=0, register the winner into grant_ch/VALID_DREG and go to PEND. VALID_DREG is visible the cycle after req_eff is seen.
  - PEND: winner held. Higher-priority requests arriving now do not preempt.
    - svc_start=1: go to SERV, set dack_act.
    - Winner's req_eff drops before svc_start (and svc_start=0): return to IDLE, VALID_DREG=0 next cycle.
    - cmd_disable rising: no effect on an already pending channel.
  - SERV: grant frozen, request changes and mask changes ignored.
    - svc_done=1: go to IDLE, clear dack_act and VALID_DREG.
    - If cmd_rotate=1, prio_ptr <= grant_ch+1 (2-bit wrap, so ch3 wraps to 0).
    - sw_req_clr[grant_ch] pulses for 1 cycle if sw_req[grant_ch]=1.
- Simultaneous svc_start and svc_done in PEND: svc_done wins and the block returns to IDLE.
- DACK outputs:
  - DACK[i] = (dack_act & grant_ch==i) XOR ~cmd_dack_high, so inactive level is 1 when active-low.
  - DACK is driven from registered state only; the polarity XOR is the only combinational term.
- Re-arbitration after SERV:
  - IDLE lasts at least 1 cycle, so back-to-back service always takes the IDLE->PEND path.
  - Arbitration then uses the updated prio_ptr.
- cmd_rotate changes:
  - 1->0: prio_ptr resets to 0 on the next clock.
  - 0->1: rotation starts from 0.
- Reset, asynchronous and effective mid-operation in any state:
  - state=IDLE, VALID_DREG=0, grant_ch=0, prio_ptr=0, dack_act=0, sw_req_clr=0, sync flops=0.
  - DACK resolves to inactive for the current cmd_dack_high.

Test Plan:
- Reset defaults: RESET_N=0 mid-SERV with grant_ch=2, cmd_dack_high=0 -> DACK=4'b1111, VALID_DREG=0, prio_ptr=0 immediately, no clock needed.
- Fixed priority: DREQ=4'b1010, mask=0 -> VALID_DREG=4'b0010, grant_ch=1 one cycle later. svc_start -> DACK=4'b1101. svc_done -> VALID_DREG=0 and DACK=4'b1111 on the next edge.
- Rotating priority: cmd_rotate=1, all DREQ high, run four svc_start/svc_done pairs -> grants 0,1,2,3 in order; prio_ptr reads 1,2,3,0.
- Masking and software requests: mask=4'b1111, DREQ=4'b1111 -> no grant. Set sw_req=4'b0100 -> grant_ch=2. On svc_done, sw_req_clr=4'b0100 for exactly 1 cycle.
- Withdrawal in PEND: DREQ[3] alone asserted, then deasserted before svc_start -> return to IDLE, VALID_DREG=0, DACK never asserted.
- Polarity and preemption: cmd_dreq_low=1, cmd_dack_high=1, DREQ=4'b1110 -> grant ch0, DACK=4'b0001 in SERV. Changing DREQ to 4'b1111 during SERV leaves grant unchanged.

Source files
------------

// File: rtl/dma_priority_arbiter.sv
// DMA channel-priority resolver and service lock: picks one requesting channel, holds it through service, drives DACK.
// Latency: DREQ->VALID_DREG is SYNC_STAGES+1 cycles (sw_req 1 cycle); backpressure: grant is held until svc_start/svc_done.
module dma_priority_arbiter #(
    parameter int SYNC_STAGES = 1
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] DREQ,
    input  logic [3:0] mask_reg,
    input  logic [3:0] sw_req,
    input  logic       cmd_disable,
    input  logic       cmd_rotate,
    input  logic       cmd_dreq_low,
    input  logic       cmd_dack_high,
    input  logic       svc_start,
    input  logic       svc_done,
    output logic [3:0] VALID_DREG,
    output logic [1:0] grant_ch,
    output logic [3:0] DACK,
    output logic [1:0] prio_ptr,
    output logic [3:0] sw_req_clr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_SERV = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_grant;
    logic [3:0] r_valid;
    logic       r_dack_act;
    logic [1:0] r_ptr;
    logic [3:0] r_clr;

    logic [3:0] w_dreq;
    logic [3:0] w_req;
    logic [1:0] w_ptr;
    logic [1:0] w_win;
    logic [1:0] w_cand;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_dreq = DREQ;
        end else begin : g_sync
            logic [3:0] r_sync [SYNC_STAGES];

            always_ff @(posedge CLK or negedge RESET_N) begin
                if (!RESET_N) begin
                    for (int s = 0; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= '0;
                    end
                end else begin
                    r_sync[0] <= DREQ;
                    for (int s = 1; s < SYNC_STAGES; s++) begin
                        r_sync[s] <= r_sync[s-1];
                    end
                end
            end

            assign w_dreq = r_sync[SYNC_STAGES-1];
        end
    endgenerate

    // Software requests bypass both the mask and the pin polarity.
    assign w_req = ((w_dreq ^ {4{cmd_dreq_low}}) & ~mask_reg) | sw_req;
    assign w_ptr = cmd_rotate ? r_ptr : 2'd0;

    // Scan from the lowest-priority slot down so the highest-priority hit is assigned last.
    always_comb begin
        w_win  = w_ptr;
        w_cand = '0;
        for (int k = 3; k >= 0; k--) begin
            w_cand = w_ptr + 2'(k);
            if (w_req[w_cand]) begin
                w_win = w_cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_valid    <= '0;
            r_dack_act <= 1'b0;
            r_ptr      <= '0;
            r_clr      <= '0;
        end else begin
            r_clr <= '0;
            if (!cmd_rotate) begin
                r_ptr <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (!cmd_disable && (|w_req)) begin
                        r_grant <= w_win;
                        r_valid <= 4'b0001 << w_win;
                        r_state <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (svc_done) begin
                        r_valid <= '0;
                        r_state <= ST_IDLE;
                    end else if (svc_start) begin
                        r_dack_act <= 1'b1;
                        r_state    <= ST_SERV;
                    end else if (!w_req[r_grant]) begin
                        r_valid <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SERV: begin
                    if (svc_done) begin
                        r_valid    <= '0;
                        r_dack_act <= 1'b0;
                        r_state    <= ST_IDLE;
                        r_clr[r_grant] <= sw_req[r_grant];
                        if (cmd_rotate) begin
                            r_ptr <= r_grant + 2'd1;
                        end
                    end
                end
                default: begin
                    r_valid    <= '0;
                    r_dack_act <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign VALID_DREG = r_valid;
    assign grant_ch   = r_grant;
    assign prio_ptr   = r_ptr;
    assign sw_req_clr = r_clr;
    assign DACK       = ({4{r_dack_act}} & r_valid) ^ {4{~cmd_dack_high}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: directed steps plus random traffic against a channel-ownership reference model.
module tb_dma_priority_arbiter;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ, mask_reg, sw_req;
    logic       cmd_disable, cmd_rotate, cmd_dreq_low, cmd_dack_high;
    logic       svc_start, svc_done;
    logic [3:0] VALID_DREG, DACK, sw_req_clr;
    logic [1:0] grant_ch, prio_ptr;

    always #5 CLK = ~CLK;

    dma_priority_arbiter #(.SYNC_STAGES(1)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .mask_reg(mask_reg), .sw_req(sw_req),
        .cmd_disable(cmd_disable), .cmd_rotate(cmd_rotate), .cmd_dreq_low(cmd_dreq_low),
        .cmd_dack_high(cmd_dack_high), .svc_start(svc_start), .svc_done(svc_done),
        .VALID_DREG(VALID_DREG), .grant_ch(grant_ch), .DACK(DACK), .prio_ptr(prio_ptr),
        .sw_req_clr(sw_req_clr)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: which channel owns the arbiter (-1 = none) and whether it is being serviced.
    logic [3:0] m_dreq_d;
    int         m_owner;
    bit         m_busy;
    int         m_ptr;
    logic [3:0] m_clr;

    task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [3:0] req, int ptr);
        for (int k = 0; k < 4; k++) begin
            if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_dreq_d = '0;
        m_owner  = -1;
        m_busy   = 0;
        m_ptr    = 0;
        m_clr    = '0;
    endtask

    task automatic check_outputs(string tag);
        logic [3:0] ev, ed;
        ev = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        ed = (m_busy ? ev : 4'b0000) ^ (cmd_dack_high ? 4'b0000 : 4'b1111);
        chk({tag, ".valid"}, VALID_DREG, ev);
        if (m_owner >= 0) chk({tag, ".grant"}, {2'b00, grant_ch}, 4'(m_owner));
        chk({tag, ".dack"}, DACK, ed);
        chk({tag, ".ptr"}, {2'b00, prio_ptr}, 4'(m_ptr));
        chk({tag, ".clr"}, sw_req_clr, m_clr);
    endtask

    task automatic tick(string tag);
        logic [3:0] req;
        int nptr;
        @(posedge CLK);
        req   = ((m_dreq_d ^ {4{cmd_dreq_low}}) & ~mask_reg) | sw_req;
        nptr  = cmd_rotate ? m_ptr : 0;
        m_clr = '0;
        if (m_owner < 0) begin
            if (!cmd_disable && req != 0) m_owner = pick(req, cmd_rotate ? m_ptr : 0);
        end else if (!m_busy) begin
            if (svc_done) m_owner = -1;
            else if (svc_start) m_busy = 1;
            else if (!req[m_owner]) m_owner = -1;
        end else if (svc_done) begin
            if (cmd_rotate) nptr = (m_owner + 1) % 4;
            m_clr[m_owner] = sw_req[m_owner];
            m_owner = -1;
            m_busy  = 0;
        end
        m_ptr    = nptr;
        m_dreq_d = DREQ;
        @(negedge CLK);
        check_outputs(tag);
    endtask

    initial begin
        RESET_N = 1'b0; DREQ = '0; mask_reg = '0; sw_req = '0;
        cmd_disable = 0; cmd_rotate = 0; cmd_dreq_low = 0; cmd_dack_high = 0;
        svc_start = 0; svc_done = 0;
        model_reset();
        #1;
        check_outputs("reset");
        chk("reset.dack_idle", DACK, 4'b1111);
        @(negedge CLK); @(negedge CLK);
        RESET_N = 1'b1;
        tick("idle");

        // Fixed priority: ch1 beats ch3
        DREQ = 4'b1010;
        tick("fix_sync");
        tick("fix_arb");
        chk("fix.valid", VALID_DREG, 4'b0010);
        chk("fix.grant", {2'b00, grant_ch}, 4'd1);
        svc_start = 1; tick("fix_start"); svc_start = 0;
        chk("fix.dack", DACK, 4'b1101);
        svc_done = 1; DREQ = '0; tick("fix_done"); svc_done = 0;
        chk("fix.valid_off", VALID_DREG, 4'b0000);
        chk("fix.dack_off", DACK, 4'b1111);
        tick("fix_idle"); tick("fix_idle");

        // Rotating priority: all channels requesting, served in turn
        cmd_rotate = 1; DREQ = 4'b1111;
        tick("rot_sync"); tick("rot_arb");
        for (int i = 0; i < 4; i++) begin
            chk("rot.grant", {2'b00, grant_ch}, 4'(i));
            svc_start = 1; tick("rot_start"); svc_start = 0;
            svc_done = 1; tick("rot_done"); svc_done = 0;
            chk("rot.ptr", {2'b00, prio_ptr}, 4'((i + 1) % 4));
            tick("rot_rearb");
        end
        DREQ = '0; cmd_rotate = 0;
        tick("rot_end"); tick("rot_end"); tick("rot_end");

        // Masking and software requests
        mask_reg = 4'b1111; DREQ = 4'b1111;
        tick("mask"); tick("mask"); tick("mask");
        chk("mask.none", VALID_DREG, 4'b0000);
        sw_req = 4'b0100;
        tick("sw_arb");
        chk("sw.grant", {2'b00, grant_ch}, 4'd2);
        svc_start = 1; tick("sw_start"); svc_start = 0;
        svc_done = 1; tick("sw_done"); svc_done = 0;
        chk("sw.clr_pulse", sw_req_clr, 4'b0100);
        sw_req = '0;
        tick("sw_after");
        chk("sw.clr_gone", sw_req_clr, 4'b0000);
        mask_reg = '0; DREQ = '0;
        tick("sw_end"); tick("sw_end");

        // Withdrawal while pending
        DREQ = 4'b1000;
        tick("wd_sync"); tick("wd_arb");
        chk("wd.valid", VALID_DREG, 4'b1000);
        DREQ = '0;
        tick("wd_drop"); tick("wd_idle");
        chk("wd.valid_off", VALID_DREG, 4'b0000);
        chk("wd.dack", DACK, 4'b1111);

        // Inverted polarities, no preemption during service
        cmd_dreq_low = 1; cmd_dack_high = 1; DREQ = 4'b1110;
        tick("pol_a"); tick("pol_b");
        chk("pol.grant", {2'b00, grant_ch}, 4'd0);
        svc_start = 1; tick("pol_start"); svc_start = 0;
        chk("pol.dack", DACK, 4'b0001);
        DREQ = 4'b1111;
        tick("pol_hold"); tick("pol_hold"); tick("pol_hold");
        chk("pol.grant_hold", {2'b00, grant_ch}, 4'd0);
        chk("pol.dack_hold", DACK, 4'b0001);
        svc_done = 1; tick("pol_done"); svc_done = 0;
        chk("pol.dack_off", DACK, 4'b0000);
        mask_reg = 4'b1111;
        tick("pol_restore");
        cmd_dreq_low = 0; cmd_dack_high = 0; DREQ = '0;
        tick("pol_restore"); tick("pol_restore"); tick("pol_restore");
        mask_reg = '0;

        // Asynchronous reset in the middle of service on ch2
        cmd_rotate = 1; sw_req = 4'b0100;
        tick("rst_arb");
        chk("rst.grant", {2'b00, grant_ch}, 4'd2);
        svc_start = 1; tick("rst_start"); svc_start = 0;
        chk("rst.dack_on", DACK, 4'b1011);
        #2 RESET_N = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid");
        chk("rst.dack_inact", DACK, 4'b1111);
        @(negedge CLK);
        RESET_N = 1'b1; sw_req = '0; cmd_rotate = 0;
        tick("rst_release");

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            DREQ      = 4'($urandom);
            mask_reg  = 4'($urandom);
            sw_req    = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
            cmd_disable = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 60) == 0) cmd_rotate = ~cmd_rotate;
            if ($urandom_range(0, 200) == 0) cmd_dreq_low = ~cmd_dreq_low;
            if ($urandom_range(0, 150) == 0) cmd_dack_high = ~cmd_dack_high;
            svc_start = ($urandom_range(0, 2) == 0);
            svc_done  = ($urandom_range(0, 4) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
